// File: rtl/alu_seq_param_if.sv
// ============================================================================
// Module   : alu_seq_param_if
// Purpose  : Request/response handshake bundle for alu_seq_param.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_seq_param_if #(
    parameter int W = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           use_acc;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           zero;
    logic           carry;
    logic [2*W-1:0] acc;

    modport master (
        output in_valid, op, a, b, use_acc, out_ready,
        input  in_ready, out_valid, result, zero, carry, acc
    );

    modport slave (
        input  in_valid, op, a, b, use_acc, out_ready,
        output in_ready, out_valid, result, zero, carry, acc
    );
endinterface

`default_nettype wire

// File: rtl/alu_seq_param.sv
// ============================================================================
// Module   : alu_seq_param
// Purpose  : Registered W-bit ALU with shift-add multiplier and accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_param #(
    parameter int W = 4
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    alu_seq_param_if.slave   bus
);
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [2:0] C_OP_ADD  = 3'b000;
    localparam logic [2:0] C_OP_SUB  = 3'b001;
    localparam logic [2:0] C_OP_NRNA = 3'b010;
    localparam logic [2:0] C_OP_XRXN = 3'b011;
    localparam logic [2:0] C_OP_BNA  = 3'b100;
    localparam logic [2:0] C_OP_MUL  = 3'b101;
    localparam logic [2:0] C_OP_ROL  = 3'b110;

    localparam logic [W-1:0]     C_W    = W'(W);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state, w_state_next;

    logic [W-1:0]     w_opa, w_sh, w_rol;
    logic [W:0]       w_sum;
    logic [2*W-1:0]   w_diff, w_alu_res, w_mul_next, w_res_new;
    logic             w_alu_carry, w_carry_new, w_accept, w_mul_last, w_produce;

    logic [2*W-1:0]   r_result, r_acc, r_mcand, r_prod;
    logic [W-1:0]     r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic             r_zero, r_carry;

    always_comb begin
        w_opa = bus.use_acc ? r_acc[W-1:0] : bus.a;
        w_sum = {1'b0, w_opa} + {1'b0, bus.b};
        w_diff = {{W{1'b0}}, w_opa} - {{W{1'b0}}, bus.b};
        w_sh = bus.b % C_W;
        // A shift by W yields 0, so a zero rotate amount needs no special case
        w_rol = (w_opa << w_sh) | (w_opa >> (C_W - w_sh));
        w_alu_res = '0;
        w_alu_carry = 1'b0;
        case (bus.op)
            C_OP_ADD: begin
                w_alu_res = {{(W-1){1'b0}}, w_sum};
                w_alu_carry = w_sum[W];
            end
            C_OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_carry = (w_opa < bus.b);
            end
            C_OP_NRNA: w_alu_res = {~(w_opa | bus.b), ~(w_opa & bus.b)};
            C_OP_XRXN: w_alu_res = {w_opa ^ bus.b, ~(w_opa ^ bus.b)};
            C_OP_BNA:  w_alu_res = {bus.b, ~w_opa};
            C_OP_ROL:  w_alu_res = {{W{1'b0}}, w_rol};
            default:   w_alu_res = '0;
        endcase
    end

    assign w_mul_next = r_prod + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_state_next = r_state;
        w_accept = 1'b0;
        w_mul_last = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_state_next = (bus.op == C_OP_MUL) ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (r_cnt == C_LAST) begin
                    w_mul_last = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_produce   = (w_accept && (bus.op != C_OP_MUL)) || w_mul_last;
    assign w_res_new   = w_mul_last ? w_mul_next : w_alu_res;
    assign w_carry_new = w_mul_last ? 1'b0 : w_alu_carry;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_result <= '0;
            r_acc    <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_produce) begin
                r_result <= w_res_new;
                r_acc    <= w_res_new;
                r_zero   <= (w_res_new == '0);
                r_carry  <= w_carry_new;
            end
            if (w_accept && (bus.op == C_OP_MUL)) begin
                r_mcand  <= {{W{1'b0}}, w_opa};
                r_mplier <= bus.b;
                r_prod   <= '0;
                r_cnt    <= '0;
            end else if (r_state == BUSY) begin
                r_prod   <= w_mul_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + C_ONE;
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.carry     = r_carry;
    assign bus.acc       = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_param.sv
// ============================================================================
// Module   : tb_alu_seq_param
// Purpose  : Scoreboard bench for alu_seq_param at W=4 and W=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_param;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    alu_seq_param_if #(.W(4)) bus4 ();
    alu_seq_param_if #(.W(8)) bus8 ();

    alu_seq_param #(.W(4)) dut4 (.clk(clk), .resetn(resetn), .bus(bus4.slave));
    alu_seq_param #(.W(8)) dut8 (.clk(clk), .resetn(resetn), .bus(bus8.slave));

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        c;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: compare on every output handshake
    always @(negedge clk) begin
        if (resetn && bus4.out_valid && bus4.out_ready) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w4 unexpected output: got %0h expected none", bus4.result);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("w4 result", 32'(bus4.result), 32'(e.res));
                check("w4 zero",   32'(bus4.zero),   32'(e.z));
                check("w4 carry",  32'(bus4.carry),  32'(e.c));
                check("w4 acc",    32'(bus4.acc),    32'(e.res));
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && bus8.out_valid && bus8.out_ready) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w8 unexpected output: got %0h expected none", bus8.result);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("w8 result", 32'(bus8.result), 32'(e.res));
                check("w8 zero",   32'(bus8.zero),   32'(e.z));
                check("w8 carry",  32'(bus8.carry),  32'(e.c));
                check("w8 acc",    32'(bus8.acc),    32'(e.res));
            end
        end
    end

    task automatic send(input bit w8, input logic [2:0] o, input logic [7:0] aa,
                        input logic [7:0] bb, input bit ua);
        if (w8) begin
            check("w8 in_ready before accept", 32'(bus8.in_ready), 32'd1);
            bus8.in_valid = 1'b1; bus8.op = o; bus8.a = aa; bus8.b = bb; bus8.use_acc = ua;
            tick();
            bus8.in_valid = 1'b0;
        end else begin
            check("w4 in_ready before accept", 32'(bus4.in_ready), 32'd1);
            bus4.in_valid = 1'b1; bus4.op = o; bus4.a = aa[3:0]; bus4.b = bb[3:0]; bus4.use_acc = ua;
            tick();
            bus4.in_valid = 1'b0;
        end
    endtask

    // Edges after the accept edge until out_valid rises; bounded
    task automatic wait_valid(input bit w8, input int exp_lat);
        int lat = 0;
        while (!(w8 ? bus8.out_valid : bus4.out_valid) && lat < 40) begin
            check(w8 ? "w8 busy in_ready" : "w4 busy in_ready",
                  32'(w8 ? bus8.in_ready : bus4.in_ready), 32'd0);
            tick();
            lat++;
        end
        check(w8 ? "w8 latency" : "w4 latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic run_op(input bit w8, input logic [2:0] o, input logic [7:0] aa,
                          input logic [7:0] bb, input bit ua, input logic [15:0] res,
                          input bit c, input int exp_lat);
        exp_t e;
        e.res = res;
        e.z = (res == 16'h0);
        e.c = c;
        if (w8) q8.push_back(e); else q4.push_back(e);
        send(w8, o, aa, bb, ua);
        wait_valid(w8, exp_lat);
        tick();
    endtask

    initial begin
        exp_t e;
        bus4.in_valid = 1'b0; bus4.op = 3'd0; bus4.a = '0; bus4.b = '0;
        bus4.use_acc = 1'b0; bus4.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.op = 3'd0; bus8.a = '0; bus8.b = '0;
        bus8.use_acc = 1'b0; bus8.out_ready = 1'b1;
        resetn = 1'b0;
        tick();
        tick();
        check("reset in_ready",  32'(bus4.in_ready),  32'd1);
        check("reset out_valid", 32'(bus4.out_valid), 32'd0);
        check("reset result",    32'(bus4.result),    32'd0);
        check("reset acc",       32'(bus4.acc),       32'd0);
        check("reset zero",      32'(bus4.zero),      32'd0);
        check("reset carry",     32'(bus4.carry),     32'd0);
        resetn = 1'b1;
        tick();

        // W=4 directed vectors: w8, op, a, b, use_acc, result, carry, latency
        run_op(0, 3'b000, 8'h9, 8'h8, 0, 16'h11, 1, 0);
        run_op(0, 3'b000, 8'hF, 8'h2, 1, 16'h03, 0, 0);
        run_op(0, 3'b001, 8'h3, 8'h5, 0, 16'hFE, 1, 0);
        run_op(0, 3'b001, 8'h5, 8'h5, 0, 16'h00, 0, 0);
        run_op(0, 3'b010, 8'hA, 8'h5, 0, 16'h0F, 0, 0);
        run_op(0, 3'b011, 8'hA, 8'h5, 0, 16'hF0, 0, 0);
        run_op(0, 3'b100, 8'h3, 8'h6, 0, 16'h6C, 0, 0);
        run_op(0, 3'b110, 8'h9, 8'h5, 0, 16'h03, 0, 0);
        run_op(0, 3'b110, 8'h9, 8'h0, 0, 16'h09, 0, 0);
        run_op(0, 3'b110, 8'h9, 8'h2, 0, 16'h06, 0, 0);
        run_op(0, 3'b111, 8'h5, 8'h3, 0, 16'h00, 0, 0);
        run_op(0, 3'b101, 8'hF, 8'hF, 0, 16'hE1, 0, 4);
        run_op(0, 3'b101, 8'h0, 8'h7, 1, 16'h07, 0, 4);
        run_op(0, 3'b000, 8'hF, 8'hF, 0, 16'h1E, 1, 0);

        // W=8 multiplier and wide ops
        run_op(1, 3'b101, 8'hFF, 8'hFF, 0, 16'hFE01, 0, 8);
        run_op(1, 3'b001, 8'h10, 8'h20, 0, 16'hFFF0, 1, 0);
        run_op(1, 3'b110, 8'h81, 8'h09, 0, 16'h0003, 0, 0);

        // Backpressure: result held, new requests ignored
        bus4.out_ready = 1'b0;
        e.res = 16'h11; e.z = 1'b0; e.c = 1'b1;
        q4.push_back(e);
        send(0, 3'b000, 8'h9, 8'h8, 0);
        wait_valid(0, 0);
        for (int i = 0; i < 3; i++) begin
            bus4.in_valid = 1'b1; bus4.op = 3'b000; bus4.a = 4'h1; bus4.b = 4'h1; bus4.use_acc = 1'b0;
            tick();
            check("bp result",    32'(bus4.result),    32'h11);
            check("bp out_valid", 32'(bus4.out_valid), 32'd1);
            check("bp in_ready",  32'(bus4.in_ready),  32'd0);
        end
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        tick();
        check("bp release in_ready",  32'(bus4.in_ready),  32'd1);
        check("bp release out_valid", 32'(bus4.out_valid), 32'd0);
        run_op(0, 3'b000, 8'hF, 8'h2, 1, 16'h03, 0, 0);

        // Reset in the middle of a multiply
        send(0, 3'b101, 8'hF, 8'hF, 0);
        tick();
        tick();
        resetn = 1'b0;
        tick();
        check("mid-mul reset out_valid", 32'(bus4.out_valid), 32'd0);
        check("mid-mul reset result",    32'(bus4.result),    32'd0);
        check("mid-mul reset acc",       32'(bus4.acc),       32'd0);
        resetn = 1'b1;
        tick();
        check("post-reset in_ready", 32'(bus4.in_ready), 32'd1);
        run_op(0, 3'b000, 8'h1, 8'h1, 0, 16'h02, 0, 0);

        tick();
        tick();
        check("w4 scoreboard drained", 32'(q4.size()), 32'd0);
        check("w8 scoreboard drained", 32'(q8.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
